// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter sharing one memory request channel between I$ (src 0) and D$ (src 1), with tid-based return routing.
// Optional: define WT_MEM_ARB_ERR_EN to add the sticky err_o flag for returns to unallocated tids.
module wt_mem_arbiter #(
    parameter int unsigned ReqWidth  = 128,
    parameter int unsigned RtrnWidth = 160,
    parameter int unsigned NumTid    = 4,
    parameter int unsigned TidWidth  = $clog2(NumTid)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 stall_i,
    output logic                 busy_o,
    input  logic                 ic_req_i,
    output logic                 ic_ack_o,
    input  logic [ReqWidth-1:0]  ic_data_i,
    output logic                 ic_rtrn_vld_o,
    output logic [RtrnWidth-1:0] ic_rtrn_o,
    input  logic                 dc_req_i,
    output logic                 dc_ack_o,
    input  logic [ReqWidth-1:0]  dc_data_i,
    output logic                 dc_rtrn_vld_o,
    output logic [RtrnWidth-1:0] dc_rtrn_o,
    output logic                 mem_req_o,
    input  logic                 mem_ack_i,
    output logic [ReqWidth-1:0]  mem_data_o,
    output logic [TidWidth-1:0]  mem_tid_o,
    input  logic                 mem_rtrn_vld_i,
    input  logic [TidWidth-1:0]  mem_rtrn_tid_i,
`ifdef WT_MEM_ARB_ERR_EN
    output logic                 err_o,
`endif
    input  logic [RtrnWidth-1:0] mem_rtrn_i
);

    typedef enum logic {IDLE, REQ} state_e;

    state_e              state_q, state_d;
    logic                rr_q, rr_d;
    logic [NumTid-1:0]   tid_vld_q, tid_vld_d;
    logic [NumTid-1:0]   src_q, src_d;
    logic [ReqWidth-1:0] data_q, data_d;
    logic [TidWidth-1:0] tid_q, tid_d;
    logic [TidWidth-1:0] free_tid;
    logic                any_free;
    logic                rtrn_hit;
    logic                rtrn_src;
    logic                winner;

    // Free tids come from registered state only, so a same-cycle return is not reused yet.
    always_comb begin
        any_free = |(~tid_vld_q);
        free_tid = '0;
        for (int i = NumTid - 1; i >= 0; i--) begin
            if (!tid_vld_q[i]) free_tid = TidWidth'(i);
        end
    end

    assign rtrn_hit = mem_rtrn_vld_i & tid_vld_q[mem_rtrn_tid_i] & ~clr_i;
    assign rtrn_src = src_q[mem_rtrn_tid_i];

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        tid_vld_d = tid_vld_q;
        src_d     = src_q;
        data_d    = data_q;
        tid_d     = tid_q;
        winner    = 1'b0;
        ic_ack_o  = 1'b0;
        dc_ack_o  = 1'b0;

        if (rtrn_hit) tid_vld_d[mem_rtrn_tid_i] = 1'b0;

        case (state_q)
            IDLE: begin
                if ((ic_req_i | dc_req_i) & ~stall_i & any_free & ~clr_i) begin
                    // On a tie the source that did not win last time goes first.
                    winner              = (ic_req_i & dc_req_i) ? ~rr_q : dc_req_i;
                    ic_ack_o            = ~winner;
                    dc_ack_o            = winner;
                    data_d              = winner ? dc_data_i : ic_data_i;
                    tid_d               = free_tid;
                    tid_vld_d[free_tid] = 1'b1;
                    src_d[free_tid]     = winner;
                    rr_d                = winner;
                    state_d             = REQ;
                end
            end
            REQ: begin
                if (mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clr_i) begin
            state_d   = IDLE;
            rr_d      = 1'b1;
            tid_vld_d = '0;
            src_d     = '0;
            data_d    = '0;
            tid_d     = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_q      <= 1'b1;
            tid_vld_q <= '0;
            src_q     <= '0;
            data_q    <= '0;
            tid_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            tid_vld_q <= tid_vld_d;
            src_q     <= src_d;
            data_q    <= data_d;
            tid_q     <= tid_d;
        end
    end

`ifdef WT_MEM_ARB_ERR_EN
    logic err_q, err_d;

    assign err_d = clr_i ? 1'b0
                         : (err_q | (mem_rtrn_vld_i & ~tid_vld_q[mem_rtrn_tid_i]));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o = err_q;
`endif

    assign mem_req_o     = (state_q == REQ);
    assign mem_data_o    = data_q;
    assign mem_tid_o     = tid_q;
    assign busy_o        = (state_q != IDLE) | (|tid_vld_q);
    assign ic_rtrn_vld_o = rtrn_hit & ~rtrn_src;
    assign dc_rtrn_vld_o = rtrn_hit & rtrn_src;
    assign ic_rtrn_o     = mem_rtrn_i;
    assign dc_rtrn_o     = mem_rtrn_i;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Bench for wt_mem_arbiter: directed vector table, reset-in-flight sequence, then random traffic against a reference model.
module tb_wt_mem_arbiter;
    localparam int ReqWidth  = 128;
    localparam int RtrnWidth = 160;
    localparam int NumTid    = 4;
    localparam int TidWidth  = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_i, clr_i, stall_i, busy_o;
    logic                 ic_req_i, ic_ack_o, ic_rtrn_vld_o;
    logic                 dc_req_i, dc_ack_o, dc_rtrn_vld_o;
    logic [ReqWidth-1:0]  ic_data_i, dc_data_i, mem_data_o;
    logic [RtrnWidth-1:0] ic_rtrn_o, dc_rtrn_o, mem_rtrn_i;
    logic                 mem_req_o, mem_ack_i, mem_rtrn_vld_i;
    logic [TidWidth-1:0]  mem_tid_o, mem_rtrn_tid_i;
`ifdef WT_MEM_ARB_ERR_EN
    logic                 err_o;
`endif

    always #5 clk_i = ~clk_i;

    wt_mem_arbiter #(.ReqWidth(ReqWidth), .RtrnWidth(RtrnWidth), .NumTid(NumTid)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .stall_i(stall_i), .busy_o(busy_o),
        .ic_req_i(ic_req_i), .ic_ack_o(ic_ack_o), .ic_data_i(ic_data_i),
        .ic_rtrn_vld_o(ic_rtrn_vld_o), .ic_rtrn_o(ic_rtrn_o),
        .dc_req_i(dc_req_i), .dc_ack_o(dc_ack_o), .dc_data_i(dc_data_i),
        .dc_rtrn_vld_o(dc_rtrn_vld_o), .dc_rtrn_o(dc_rtrn_o),
        .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o),
        .mem_tid_o(mem_tid_o), .mem_rtrn_vld_i(mem_rtrn_vld_i),
        .mem_rtrn_tid_i(mem_rtrn_tid_i),
`ifdef WT_MEM_ARB_ERR_EN
        .err_o(err_o),
`endif
        .mem_rtrn_i(mem_rtrn_i)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [RtrnWidth-1:0] act,
                       input logic [RtrnWidth-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        bit       ic, dc, st, ack, rv;
        bit [1:0] rt;
        bit       clr;
        bit       e_ica, e_dca, e_mreq;
        bit [1:0] e_tid;
        bit [7:0] e_data;
        bit       e_icr, e_dcr, e_busy, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit ic, bit dc, bit st, bit ack, bit rv, bit [1:0] rt, bit clr,
                                bit ica, bit dca, bit mreq, bit [1:0] tid, bit [7:0] data,
                                bit icr, bit dcr, bit busy, bit err);
        vec_t v;
        v = '{ic, dc, st, ack, rv, rt, clr, ica, dca, mreq, tid, data, icr, dcr, busy, err};
        vecs.push_back(v);
    endfunction

    function automatic logic [ReqWidth-1:0] rnd_req();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [RtrnWidth-1:0] rnd_rtrn();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle_inputs();
        ic_req_i = 0; dc_req_i = 0; stall_i = 0; mem_ack_i = 0; clr_i = 0;
        mem_rtrn_vld_i = 0; mem_rtrn_tid_i = '0; mem_rtrn_i = '0;
    endtask

    // Reference model: owner[t] = -1 when free, else the owning source.
    int                  m_owner[NumTid];
    bit                  m_pend;
    logic [TidWidth-1:0] m_ptid;
    logic [ReqWidth-1:0] m_pdata;
    int                  m_last;
    bit                  m_err;

    function automatic void model_reset();
        for (int i = 0; i < NumTid; i++) m_owner[i] = -1;
        m_pend = 0; m_ptid = '0; m_pdata = '0; m_last = 1; m_err = 0;
    endfunction

    initial begin
        bit ic_hold, dc_hold, grant, hit, unalloc, e_icr, e_dcr, e_busy;
        int ft, win;

        idle_inputs();
        ic_data_i = '0; dc_data_i = '0;
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mem_req", 160'(mem_req_o), 160'(0));
        chk("rst_mem_data", 160'(mem_data_o), 160'(0));
        chk("rst_mem_tid", 160'(mem_tid_o), 160'(0));
        chk("rst_busy", 160'(busy_o), 160'(0));
        chk("rst_acks", 160'({ic_ack_o, dc_ack_o, ic_rtrn_vld_o, dc_rtrn_vld_o}), 160'(0));
        rst_i = 0;

        //  ic dc st ak rv rt cl | ica dca mrq tid data  icr dcr bsy err
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 8'hA5, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 8'hA5, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 8'h00, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0,   1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 8'hA5, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 0, 0,   0, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 0, 0,   0, 0, 1, 1, 8'h5A, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 0, 0,   1, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 0, 0,   0, 0, 1, 2, 8'hA5, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 0, 0,   0, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 0, 0,   0, 0, 1, 3, 8'h5A, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        add(1, 1, 0, 0, 1, 2, 0,   0, 0, 0, 0, 8'h00, 1, 0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 2, 8'hA5, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 8'h00, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 8'h00, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 2, 0,   0, 0, 0, 0, 8'h00, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 3, 0,   0, 0, 0, 0, 8'h00, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 8'hA5, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1,   0, 0, 1, 0, 8'hA5, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0,   0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0, 0, 0, 0);

        ic_data_i = ReqWidth'(8'hA5);
        dc_data_i = ReqWidth'(8'h5A);
        foreach (vecs[k]) begin
            ic_req_i = vecs[k].ic; dc_req_i = vecs[k].dc; stall_i = vecs[k].st;
            mem_ack_i = vecs[k].ack; mem_rtrn_vld_i = vecs[k].rv;
            mem_rtrn_tid_i = vecs[k].rt; clr_i = vecs[k].clr;
            mem_rtrn_i = RtrnWidth'(k + 32'h100);
            #3;
            chk($sformatf("v%0d_ic_ack", k), 160'(ic_ack_o), 160'(vecs[k].e_ica));
            chk($sformatf("v%0d_dc_ack", k), 160'(dc_ack_o), 160'(vecs[k].e_dca));
            chk($sformatf("v%0d_mem_req", k), 160'(mem_req_o), 160'(vecs[k].e_mreq));
            if (vecs[k].e_mreq) begin
                chk($sformatf("v%0d_mem_tid", k), 160'(mem_tid_o), 160'(vecs[k].e_tid));
                chk($sformatf("v%0d_mem_data", k), 160'(mem_data_o), 160'(vecs[k].e_data));
            end
            chk($sformatf("v%0d_ic_rvld", k), 160'(ic_rtrn_vld_o), 160'(vecs[k].e_icr));
            chk($sformatf("v%0d_dc_rvld", k), 160'(dc_rtrn_vld_o), 160'(vecs[k].e_dcr));
            chk($sformatf("v%0d_busy", k), 160'(busy_o), 160'(vecs[k].e_busy));
`ifdef WT_MEM_ARB_ERR_EN
            chk($sformatf("v%0d_err", k), 160'(err_o), 160'(vecs[k].e_err));
`endif
            @(posedge clk_i);
            #1;
        end

        // Reset asserted while a request is outstanding drops mem_req_o at once.
        idle_inputs();
        ic_req_i = 1;
        @(posedge clk_i);
        #1;
        ic_req_i = 0;
        #2;
        chk("rstmid_req_before", 160'(mem_req_o), 160'(1));
        rst_i = 1;
        #1;
        chk("rstmid_req_after", 160'(mem_req_o), 160'(0));
        chk("rstmid_busy_after", 160'(busy_o), 160'(0));
        @(posedge clk_i);
        #1;
        rst_i = 0;
        model_reset();

        ic_hold = 0; dc_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!ic_hold) begin
                ic_req_i = ($urandom % 3) == 0; ic_data_i = rnd_req(); ic_hold = ic_req_i;
            end
            if (!dc_hold) begin
                dc_req_i = ($urandom % 3) == 0; dc_data_i = rnd_req(); dc_hold = dc_req_i;
            end
            stall_i        = ($urandom % 5) == 0;
            mem_ack_i      = $urandom % 2;
            mem_rtrn_vld_i = ($urandom % 5) < 2;
            mem_rtrn_tid_i = TidWidth'($urandom_range(NumTid - 1, 0));
            mem_rtrn_i     = rnd_rtrn();
            clr_i          = ($urandom % 50) == 0;

            ft = -1;
            for (int i = NumTid - 1; i >= 0; i--) if (m_owner[i] < 0) ft = i;
            grant   = !m_pend && !clr_i && !stall_i && (ic_req_i || dc_req_i) && ft >= 0;
            win     = (ic_req_i && dc_req_i) ? 1 - m_last : (ic_req_i ? 0 : 1);
            unalloc = mem_rtrn_vld_i && m_owner[mem_rtrn_tid_i] < 0;
            hit     = mem_rtrn_vld_i && !clr_i && m_owner[mem_rtrn_tid_i] >= 0;
            e_icr   = hit && m_owner[mem_rtrn_tid_i] == 0;
            e_dcr   = hit && m_owner[mem_rtrn_tid_i] == 1;
            e_busy  = m_pend;
            for (int i = 0; i < NumTid; i++) if (m_owner[i] >= 0) e_busy = 1;

            #3;
            chk("rnd_ic_ack", 160'(ic_ack_o), 160'(grant && win == 0));
            chk("rnd_dc_ack", 160'(dc_ack_o), 160'(grant && win == 1));
            chk("rnd_mem_req", 160'(mem_req_o), 160'(m_pend));
            if (m_pend) begin
                chk("rnd_mem_tid", 160'(mem_tid_o), 160'(m_ptid));
                chk("rnd_mem_data", 160'(mem_data_o), 160'(m_pdata));
            end
            chk("rnd_ic_rvld", 160'(ic_rtrn_vld_o), 160'(e_icr));
            chk("rnd_dc_rvld", 160'(dc_rtrn_vld_o), 160'(e_dcr));
            chk("rnd_ic_rtrn", ic_rtrn_o, mem_rtrn_i);
            chk("rnd_dc_rtrn", dc_rtrn_o, mem_rtrn_i);
            chk("rnd_busy", 160'(busy_o), 160'(e_busy));
`ifdef WT_MEM_ARB_ERR_EN
            chk("rnd_err", 160'(err_o), 160'(m_err));
`endif
            @(posedge clk_i);
            if (clr_i) begin
                model_reset();
            end else begin
                if (unalloc) m_err = 1;
                if (hit) m_owner[mem_rtrn_tid_i] = -1;
                if (grant) begin
                    m_owner[ft] = win;
                    m_pend  = 1;
                    m_ptid  = TidWidth'(ft);
                    m_pdata = win ? dc_data_i : ic_data_i;
                    m_last  = win;
                end else if (m_pend && mem_ack_i) begin
                    m_pend = 0;
                end
            end
            if (grant && win == 0) ic_hold = 0;
            if (grant && win == 1) dc_hold = 0;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wt_mem_arbiter.md
Name: wt_mem_arbiter

Overview:
- Shares the single memory request channel of the write-through cache subsystem between the I$ (source 0) and the D$ (source 1).
- Round-robin arbitration; the winning request is latched and held on the memory side until accepted.
- Each request gets a transaction ID (tid) from a free pool; returns are routed back to the owning cache by tid lookup.
- Sits between cva6_icache/wt_dcache and the memory adapter.

Parameters:
ReqWidth, 128, request payload width (address, size, data, type), opaque to this block
RtrnWidth, 160, return payload width, opaque
NumTid, 4, number of tids, i.e. maximum outstanding requests (power of two, >=2)
TidWidth, $clog2(NumTid), tid field width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clr_i  in  1  synchronous clear of all state
stall_i  in  1  block new grants
busy_o  out  1  FSM not IDLE or any tid allocated
ic_req_i  in  1  I$ request, held until ic_ack_o
ic_ack_o  out  1  one-cycle accept pulse to I$
ic_data_i  in  ReqWidth  I$ request payload
ic_rtrn_vld_o  out  1  return valid to I$
ic_rtrn_o  out  RtrnWidth  return payload to I$
dc_req_i / dc_ack_o / dc_data_i / dc_rtrn_vld_o / dc_rtrn_o  as above, for D$
mem_req_o  out  1  request to adapter, held until mem_ack_i
mem_ack_i  in  1  adapter accept
mem_data_o  out  ReqWidth  latched payload
mem_tid_o  out  TidWidth  tid of latched request
mem_rtrn_vld_i  in  1  return valid
mem_rtrn_tid_i  in  TidWidth  return tid
mem_rtrn_i  in  RtrnWidth  return payload

Behaviour:
- Reset values: all outputs 0; tid_vld_q = 0; src_q = 0; rr_q = 1 (I$ wins first tie); FSM = IDLE.
- FSM IDLE:
  - A grant occurs when (ic_req_i | dc_req_i) & !stall_i & any free tid.
  - free is computed from registered tid_vld_q only; a tid freed by a return in the same cycle is not reused until the next cycle.
  - Winner: if only one source requests, that source wins. On a tie, the source != rr_q wins.
  - Grant cycle actions:
    - the winner's ack pulses combinationally;
    - payload is latched;
    - the lowest-index free tid is latched and set valid, with src_q[tid] = winner;
    - rr_q <= winner;
    - next state = REQ.
- FSM REQ:
  - mem_req_o = 1; mem_data_o and mem_tid_o are stable.
  - On mem_ack_i, next state = IDLE.
  - Sustained throughput is therefore at most one request per 2 cycles.
  - stall_i has no effect in REQ.
- Ack rules:
  - ic_ack_o and dc_ack_o are never high in the same cycle.
  - An ack is never asserted without the corresponding req.
- Returns (combinational, zero latency):
  - If mem_rtrn_vld_i and tid_vld_q[mem_rtrn_tid_i], pulse the rtrn_vld_o of src_q[tid], pass mem_rtrn_i to both rtrn_o buses, and clear tid_vld_q[tid] next edge.
  - A return to an unallocated tid is dropped; no rtrn_vld_o is asserted.
- Simultaneous grant and return: both take effect. The grant's set and the return's clear always target different tids.
- All tids allocated: no grant; requesters wait with req held.
- clr_i:
  - next edge: FSM = IDLE, tid_vld_q = 0, rr_q = 1; mem_req_o drops; no ack is issued that cycle;
  - returns arriving during clr_i are dropped.
- rst_i mid-transaction: all state clears immediately (asynchronous); mem_req_o deasserts without waiting for mem_ack_i.
- busy_o = (state != IDLE) | (|tid_vld_q), registered-state based.

Optional Feature:
- Macro: WT_MEM_ARB_ERR_EN.
- Defined: adds output err_o (1 bit), a sticky flag that sets on a return to an unallocated tid and clears only on rst_i/clr_i.
- Undefined: port absent; such returns are silently dropped.

Test Plan:
- Single I$ request:
  - ic_req_i=1, data=0xA5 at cycle 0 -> ic_ack_o pulse at cycle 0.
  - mem_req_o=1 with tid=0 from cycle 1 until mem_ack_i.
  - return tid=0 -> ic_rtrn_vld_o=1 for one cycle, dc_rtrn_vld_o=0.
- Tie fairness: both requesting continuously, mem_ack_i tied high, returns withheld -> grant order I$, D$, I$, D$ with tids 0,1,2,3; then no grant; busy_o=1.
- Pool full: after the 4 grants above, return tid=2 -> next grant the following cycle reuses tid 2 and goes to the source whose turn it is.
- Stall: stall_i=1 with ic_req_i=1 -> no ack, mem_req_o=0. Deassert stall_i -> ack in that same cycle.
- clr_i in REQ: clr_i pulse while mem_req_o=1 with no ack -> mem_req_o=0 next cycle, busy_o=0, tid pool empty.
- Unallocated return: mem_rtrn_vld_i with tid=3 when idle -> no rtrn_vld_o. With WT_MEM_ARB_ERR_EN, err_o=1 and it stays set until clr_i.
